// File: rtl/univ_shift_pkg.sv
// ============================================================================
// Module      : univ_shift_pkg
// Description : Mode encoding, FSM state type and burst-legality helper for
//               the universal shift register. Honours UNIV_SHREG_ARITH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package univ_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_LOAD = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_RSVD = 3'd7;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Only modes that actually move bits are worth running as a burst.
  function automatic logic mode_is_burstable(input logic [2:0] m);
    logic r;
    r = 1'b0;
    case (m)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: r = 1'b1;
`ifdef UNIV_SHREG_ARITH_EN
      MODE_ASR: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_step.sv
// ============================================================================
// Module      : shift_step
// Description : Combinational one-step next value of the shift register.
//               Mode 6 is ASR only when UNIV_SHREG_ARITH_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [2:0]       mode,
  input  logic             d_l,
  input  logic             d_r,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    case (mode)
      MODE_SHL:  nxt = {cur[WIDTH-2:0], d_l};
      MODE_SHR:  nxt = {d_r, cur[WIDTH-1:1]};
      MODE_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      MODE_LOAD: nxt = pdata;
`ifdef UNIV_SHREG_ARITH_EN
      MODE_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
`endif
      default:   nxt = cur;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/univ_shift_reg.sv
// ============================================================================
// Module      : univ_shift_reg
// Description : Universal shift register with single-step path and burst
//               engine (busy/done). UNIV_SHREG_ARITH_EN enables ASR (mode 6).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             d_l,
  input  logic             d_r,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] out,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic [2:0]       r_mode_q, w_mode_q_nxt;
  logic [CNT_W-1:0] r_remaining, w_remaining_nxt;
  logic             r_done, w_done_nxt;
  logic [2:0]       w_step_mode;
  logic [WIDTH-1:0] w_step_val;

  // One stepper serves both paths; in RUN the latched mode drives it.
  assign w_step_mode = (r_state == RUN) ? r_mode_q : mode;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur   (r_out),
    .mode  (w_step_mode),
    .d_l   (d_l),
    .d_r   (d_r),
    .pdata (pdata),
    .nxt   (w_step_val)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_out       <= '0;
      r_mode_q    <= MODE_HOLD;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out       <= w_out_nxt;
      r_mode_q    <= w_mode_q_nxt;
      r_remaining <= w_remaining_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_out_nxt       = r_out;
    w_mode_q_nxt    = r_mode_q;
    w_remaining_nxt = r_remaining;
    w_done_nxt      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_mode_q_nxt    = mode;
          w_remaining_nxt = count;
          // Degenerate bursts finish immediately without touching out.
          if (count == '0 || !mode_is_burstable(mode)) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = RUN;
          end
        end else if (en) begin
          w_out_nxt = w_step_val;
        end
      end
      RUN: begin
        w_out_nxt = w_step_val;
        if (r_remaining != '0) begin
          w_remaining_nxt = r_remaining - {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (r_remaining <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign out    = r_out;
  assign sout_l = r_out[WIDTH-1];
  assign sout_r = r_out[0];
  assign busy   = (r_state == RUN);
  assign done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Self-checking bench for univ_shift_reg with a randomised
//               arithmetic reference model. Follows UNIV_SHREG_ARITH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_univ_shift_reg;

  localparam int W = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = '0;
  logic          d_l = 1'b0;
  logic          d_r = 1'b0;
  logic [W-1:0]  pdata = '0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic [W-1:0]  out;
  logic          sout_l, sout_r, busy, done;

  int n_cmp = 0;
  int n_err = 0;
  int ref_out = 0;

  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode), .d_l(d_l), .d_r(d_r),
    .pdata(pdata), .start(start), .count(count), .out(out),
    .sout_l(sout_l), .sout_r(sout_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: each mode expressed as integer arithmetic on the value.
  function automatic int model_step(int m, int v, int dl, int dr, int pd);
    int top = 2 ** (W - 1);
    case (m)
      1: return (v * 2) % (2 * top) + dl;
      2: return v / 2 + dr * top;
      3: return (v * 2) % (2 * top) + v / top;
      4: return v / 2 + (v % 2) * top;
      5: return pd;
`ifdef UNIV_SHREG_ARITH_EN
      6: return v / 2 + (v >= top ? top : 0);
`endif
      default: return v;
    endcase
  endfunction

  function automatic bit model_burstable(int m);
`ifdef UNIV_SHREG_ARITH_EN
    return (m >= 1 && m <= 4) || m == 6;
`else
    return m >= 1 && m <= 4;
`endif
  endfunction

  task automatic load(input logic [W-1:0] v);
    en = 1'b1; mode = 3'd5; pdata = v;
    tick();
    en = 1'b0;
    ref_out = int'(v);
  endtask

  task automatic single(input logic [2:0] m, input logic dl, input logic dr);
    en = 1'b1; mode = m; d_l = dl; d_r = dr; pdata = W'($urandom);
    tick();
    en = 1'b0;
    ref_out = model_step(int'(m), ref_out, int'(dl), int'(dr), int'(pdata));
  endtask

  // Issues a start and watches ~20 cycles, updating ref_out per edge.
  // Cycle 1 is the first cycle after the edge that samples start.
  task automatic do_burst(input logic [2:0] m, input logic [CW-1:0] c,
                          output int exp_busy, output int busy_cyc,
                          output int done_cyc, output int done_cnt);
    int steps;
    steps = (c != 0 && model_burstable(int'(m))) ? int'(c) : 0;
    exp_busy = steps;
    busy_cyc = 0; done_cyc = -1; done_cnt = 0;
    start = 1'b1; mode = m; count = c; en = 1'($urandom);
    tick();
    start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = k;
      end
      d_l = 1'($urandom); d_r = 1'($urandom);
      mode = 3'($urandom); count = CW'($urandom); pdata = W'($urandom);
      en = (k <= steps) ? 1'($urandom) : 1'b0;
      tick();
      if (k <= steps) ref_out = model_step(int'(m), ref_out, int'(d_l), int'(d_r), 0);
    end
    mode = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #3;
    n_cmp++;
    if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: out=%h busy=%b done=%b, want 00/0/0", out, busy, done);
    end
    tick();
    rstn = 1'b1;
    tick();
    load(8'hA5);
    start = 1'b1; mode = 3'd3; count = 4'd5;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_busy_before: busy=%b want 1", busy);
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if (out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_burst: out=%h busy=%b done=%b, want 00/0/0", out, busy, done);
    end
    tick();
    rstn = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 8; k++) begin
        tick();
        if (done || busy) seen++;
      end
      n_cmp++;
      if (seen != 0 || out !== '0) begin
        n_err++;
        $display("FAIL reset_no_done: busy/done cycles=%0d out=%h, want 0 and 00", seen, out);
      end
    end
    ref_out = 0;
  endtask

  task automatic test_single_steps();
    logic [W-1:0] exp [3] = '{8'h02, 8'h01, 8'h80};
    logic [2:0]   md  [3] = '{3'd1, 3'd4, 3'd2};
    logic         dls [3] = '{1'b0, 1'b0, 1'b0};
    logic         drs [3] = '{1'b0, 1'b0, 1'b1};
    load(8'h81);
    for (int i = 0; i < 3; i++) begin
      single(md[i], dls[i], drs[i]);
      n_cmp++;
      if (out !== exp[i] || sout_l !== exp[i][W-1] || sout_r !== exp[i][0]) begin
        n_err++;
        $display("FAIL single_step_%0d: out=%h sl=%b sr=%b, want %h", i, out, sout_l, sout_r, exp[i]);
      end
    end
    en = 1'b0; mode = 3'd1; d_l = 1'b1;
    tick();
    n_cmp++;
    if (out !== 8'h80) begin
      n_err++;
      $display("FAIL en_low_hold: out=%h want 80", out);
    end
  endtask

  task automatic test_burst();
    int eb, bc, dc, dn;
    load(8'hF0);
    do_burst(3'd3, 4'd4, eb, bc, dc, dn);
    n_cmp++;
    if (bc != 4 || dc != 5 || dn != 1 || out !== 8'h0F) begin
      n_err++;
      $display("FAIL burst_rol4: busy=%0d done_cyc=%0d pulses=%0d out=%h, want 4/5/1/0f", bc, dc, dn, out);
    end
  endtask

  task automatic test_degenerate();
    int eb, bc, dc, dn;
    load(8'h3C);
    do_burst(3'd1, 4'd0, eb, bc, dc, dn);
    n_cmp++;
    if (bc != 0 || dc != 1 || dn != 1 || out !== 8'h3C) begin
      n_err++;
      $display("FAIL zero_count: busy=%0d done_cyc=%0d pulses=%0d out=%h, want 0/1/1/3c", bc, dc, dn, out);
    end
    do_burst(3'd5, 4'd3, eb, bc, dc, dn);
    n_cmp++;
    if (bc != 0 || dc != 1 || dn != 1 || out !== 8'h3C) begin
      n_err++;
      $display("FAIL load_burst: busy=%0d done_cyc=%0d pulses=%0d out=%h, want 0/1/1/3c", bc, dc, dn, out);
    end
  endtask

  task automatic test_back_to_back();
    load(8'hFF);
    d_r = 1'b0;
    start = 1'b1; mode = 3'd2; count = 4'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || out !== 8'h3F) begin
      n_err++;
      $display("FAIL b2b_first: done=%b busy=%b out=%h, want 1/0/3f", done, busy, out);
    end
    start = 1'b1; mode = 3'd2; count = 4'd1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_accept: busy=%b want 1", busy);
    end
    tick();
    n_cmp++;
    if (out !== 8'h1F || done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_final: out=%h done=%b busy=%b, want 1f/1/0", out, done, busy);
    end
    ref_out = 8'h1F;
  endtask

  task automatic test_asr();
    int eb, bc, dc, dn;
    load(8'h80);
    do_burst(3'd6, 4'd3, eb, bc, dc, dn);
    n_cmp++;
`ifdef UNIV_SHREG_ARITH_EN
    if (bc != 3 || dc != 4 || dn != 1 || out !== 8'hF0) begin
      n_err++;
      $display("FAIL asr_burst: busy=%0d done_cyc=%0d pulses=%0d out=%h, want 3/4/1/f0", bc, dc, dn, out);
    end
`else
    if (bc != 0 || dc != 1 || dn != 1 || out !== 8'h80) begin
      n_err++;
      $display("FAIL asr_off: busy=%0d done_cyc=%0d pulses=%0d out=%h, want 0/1/1/80", bc, dc, dn, out);
    end
`endif
  endtask

  task automatic test_random();
    int eb, bc, dc, dn, edc;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        en = 1'($urandom); mode = 3'($urandom); d_l = 1'($urandom);
        d_r = 1'($urandom); pdata = W'($urandom);
        tick();
        if (en) ref_out = model_step(int'(mode), ref_out, int'(d_l), int'(d_r), int'(pdata));
        en = 1'b0;
        n_cmp++;
        if (out !== W'(ref_out) || sout_l !== out[W-1] || sout_r !== out[0]) begin
          n_err++;
          $display("FAIL rand_step_%0d: out=%h sl=%b sr=%b, want %h", i, out, sout_l, sout_r, W'(ref_out));
        end
      end else begin
        do_burst(3'($urandom), CW'($urandom), eb, bc, dc, dn);
        edc = eb + 1;
        n_cmp++;
        if (bc != eb || dc != edc || dn != 1 || out !== W'(ref_out)) begin
          n_err++;
          $display("FAIL rand_burst_%0d: busy=%0d done_cyc=%0d pulses=%0d out=%h, want %0d/%0d/1/%h",
                   i, bc, dc, dn, out, eb, edc, W'(ref_out));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_steps();
    test_burst();
    test_degenerate();
    test_back_to_back();
    test_asr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
